// File: rtl/add_arb_pkg.sv
// Shared definitions for the add_arbiter slice.
//   ADD_W       : operand width of the shared adder (64)
//   arb_state_t : output-buffer state, EMPTY or FULL
//   add_res_t   : adder result, {sum[63:0], cout}
package add_arb_pkg;

    localparam int ADD_W = 64;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic [ADD_W-1:0] sum;
        logic             cout;
    } add_res_t;

endpackage

// File: rtl/add64_cs.sv
// Combinational 64-bit carry-select adder.
//   a, b : operands (ADD_W bits)
//   cin  : carry-in
//   res  : {sum, cout}; cout is bit 64 of a + b + cin
// The upper 32-bit half is computed for both possible carries and selected
// by the carry-out of the lower half.
module add64_cs
    import add_arb_pkg::*;
(
    input  logic [ADD_W-1:0] a,
    input  logic [ADD_W-1:0] b,
    input  logic             cin,
    output add_res_t         res
);

    logic [32:0] lo;
    logic [32:0] hi0;
    logic [32:0] hi1;

    assign lo  = {1'b0, a[31:0]} + {1'b0, b[31:0]} + {32'd0, cin};
    assign hi0 = {1'b0, a[63:32]} + {1'b0, b[63:32]};
    assign hi1 = {1'b0, a[63:32]} + {1'b0, b[63:32]} + 33'd1;

    assign res.sum  = {(lo[32] ? hi1[31:0] : hi0[31:0]), lo[31:0]};
    assign res.cout = lo[32] ? hi1[32] : hi0[32];

endmodule

// File: rtl/add_arbiter.sv
// Shares one 64-bit carry-select adder among N_REQ requesters and buffers the
// result in a single-entry output register tagged with the requester index.
//
// Ports:
//   clk, rst              : clock (rising edge), async active-high reset
//   req_valid/req_ready   : per-requester handshake (req_ready one-hot or 0)
//   req_a, req_b          : operands, requester i at [i*W +: W]
//   req_cin               : per-requester carry-in
//   res_valid/res_ready   : output handshake
//   res_sum, res_cout     : registered 65-bit result
//   res_id                : index of the requester that produced the result
//   op_count              : completed output handshakes, wraps at 2^32
//   dbg_state             : output-buffer FSM state
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. req_ready is combinational from req_valid and res_ready, so a
// requester must not derive req_valid from req_ready, and must hold its
// operands stable until the accepting edge. res_* are stable while
// res_valid=1 and res_ready=0.
//
// Build option: define ADD_ARB_RR_EN for round-robin arbitration with a
// rotating priority pointer; otherwise fixed priority, lowest index wins.
module add_arbiter
    import add_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int W     = ADD_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*W-1:0]       req_a,
    input  logic [N_REQ*W-1:0]       req_b,
    input  logic [N_REQ-1:0]         req_cin,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [W-1:0]             res_sum,
    output logic                     res_cout,
    output logic [$clog2(N_REQ)-1:0] res_id,
    output logic [31:0]              op_count,
    output arb_state_t               dbg_state
);

    localparam int IW = $clog2(N_REQ);

    arb_state_t      state_q, state_d;
    add_res_t        res_q;
    add_res_t        add_out;
    logic [IW-1:0]   id_q;
    logic [31:0]     count_q;
    logic [IW-1:0]   prio_w;

    logic [N_REQ-1:0] grant;
    logic             found;
    logic [IW-1:0]    gnt_idx;
    logic [IW-1:0]    idx;
    logic [W-1:0]     a_sel;
    logic [W-1:0]     b_sel;
    logic             cin_sel;
    logic             can_accept;
    logic             accept;
    logic             drain;

    // Search rises from prio_w modulo N_REQ; IW-bit addition wraps naturally
    // because N_REQ is a power of two.
    always_comb begin
        grant   = '0;
        found   = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        a_sel   = '0;
        b_sel   = '0;
        cin_sel = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = prio_w + IW'(k);
            if (!found && req_valid[idx]) begin
                found   = 1'b1;
                gnt_idx = idx;
            end
        end
        grant[gnt_idx] = found;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                a_sel   = req_a[i*W +: W];
                b_sel   = req_b[i*W +: W];
                cin_sel = req_cin[i];
            end
        end
    end

    add64_cs u_add (
        .a   (a_sel),
        .b   (b_sel),
        .cin (cin_sel),
        .res (add_out)
    );

    assign drain      = (state_q == FULL) && res_ready;
    assign can_accept = ((state_q == EMPTY) || res_ready) && !rst;
    assign accept     = found && can_accept;
    assign req_ready  = grant & {N_REQ{can_accept}};

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (accept) state_d = FULL;
            FULL:    if (accept) state_d = FULL;
                     else if (res_ready) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            res_q   <= '0;
            id_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                res_q <= add_out;
                id_q  <= gnt_idx;
            end
            if (drain) begin
                count_q <= count_q + 32'd1;
            end
        end
    end

`ifdef ADD_ARB_RR_EN
    logic [IW-1:0] prio_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q <= '0;
        end else if (accept) begin
            prio_q <= gnt_idx + IW'(1);
        end
    end

    assign prio_w = prio_q;
`else
    assign prio_w = '0;
`endif

    assign res_valid = (state_q == FULL);
    assign res_sum   = res_q.sum;
    assign res_cout  = res_q.cout;
    assign res_id    = id_q;
    assign op_count  = count_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_add_arbiter.sv
// Self-checking bench for add_arbiter: directed cases with literal
// expectations followed by randomized traffic, all compared every cycle
// against a behavioural model of the arbiter and output buffer.
module tb_add_arbiter;
    import add_arb_pkg::*;

    localparam int N  = 4;
    localparam int W  = 64;
    localparam int IW = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [N-1:0]     req_cin;
    logic             res_valid;
    logic             res_ready;
    logic [W-1:0]     res_sum;
    logic             res_cout;
    logic [IW-1:0]    res_id;
    logic [31:0]      op_count;
    arb_state_t       dbg_state;

    add_arbiter #(.N_REQ(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_cout  (res_cout),
        .res_id    (res_id),
        .op_count  (op_count),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    logic check_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [W-1:0]  exp_q[$];   // sum of the result currently held (0 or 1 entry)
    logic          m_full;
    logic          m_cout;
    logic [IW-1:0] m_id;
    logic [IW-1:0] m_prio;
    logic [31:0]   m_count;
    logic [N-1:0]  m_acc;      // requesters accepted at the most recent edge
    logic [W:0]    m_sum65;
    int            m_w;
    logic          m_hs;

    // First valid requester at or above prio, wrapping; -1 if none.
    function automatic int winner(input logic [N-1:0] v, input logic [IW-1:0] p);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (int'(p) + k) % N;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        int w;
        logic [N-1:0] r;
        r = '0;
        w = winner(req_valid, m_prio);
        if (!rst && (!m_full || res_ready) && w >= 0) r[w] = 1'b1;
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_full  = 1'b0;
            m_cout  = 1'b0;
            m_id    = '0;
            m_prio  = '0;
            m_count = '0;
            m_acc   = '0;
            exp_q.delete();
        end else begin
            m_hs  = m_full && res_ready;
            m_w   = winner(req_valid, m_prio);
            m_acc = '0;
            if (m_hs) begin
                m_count = m_count + 32'd1;
                void'(exp_q.pop_front());
            end
            if ((!m_full || res_ready) && m_w >= 0) begin
                m_sum65 = {1'b0, req_a[m_w*W +: W]} + {1'b0, req_b[m_w*W +: W]}
                          + {64'd0, req_cin[m_w]};
                exp_q.push_back(m_sum65[W-1:0]);
                m_cout      = m_sum65[W];
                m_id        = IW'(m_w);
                m_full      = 1'b1;
                m_acc[m_w]  = 1'b1;
`ifdef ADD_ARB_RR_EN
                m_prio = IW'((m_w + 1) % N);
`endif
            end else if (m_hs) begin
                m_full = 1'b0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (check_en) begin
                chk("res_valid", res_valid, m_full);
                chk("dbg_state", dbg_state, m_full ? FULL : EMPTY);
                chk("op_count", op_count, m_count);
                chk("req_ready", req_ready, exp_ready());
                if (m_full) begin
                    chk("res_sum", res_sum, exp_q[0]);
                    chk("res_cout", res_cout, m_cout);
                    chk("res_id", res_id, m_id);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle();
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin);
        req_valid[i]     = 1'b1;
        req_a[i*W +: W]  = a;
        req_b[i*W +: W]  = b;
        req_cin[i]       = cin;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        res_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [W-1:0] rnd64();
        logic [W-1:0] v;
        case ($urandom_range(0, 4))
            0:       v = '0;
            1:       v = '1;
            2:       v = 64'd1 << $urandom_range(0, 63);
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    int           rr_ids[5];
    logic [N-1:0] pend;

    initial begin
`ifdef ADD_ARB_RR_EN
        rr_ids = '{0, 1, 2, 3, 0};
`else
        rr_ids = '{0, 0, 0, 0, 0};
`endif
        rst = 1'b1;
        idle();
        res_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_en = 1'b1;
        #1;
        chk("rst_valid", res_valid, 1'b0);
        chk("rst_sum", res_sum, 64'd0);
        chk("rst_cout", res_cout, 1'b0);
        chk("rst_id", res_id, 2'd0);
        chk("rst_count", op_count, 32'd0);
        chk("rst_ready", req_ready, 4'b0000);

        // Single request from requester 2.
        @(negedge clk);
        set_req(2, 64'hFFFF_FFFF, 64'd1, 1'b0);
        res_ready = 1'b1;
        #1 chk("t1_ready", req_ready, 4'b0100);
        @(negedge clk);
        idle();
        #1;
        chk("t1_valid", res_valid, 1'b1);
        chk("t1_sum", res_sum, 64'h1_0000_0000);
        chk("t1_cout", res_cout, 1'b0);
        chk("t1_id", res_id, 2'd2);
        @(negedge clk);
        #1;
        chk("t1_count", op_count, 32'd1);
        chk("t1_drained", res_valid, 1'b0);

        // Carry-out.
        @(negedge clk);
        set_req(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
        @(negedge clk);
        idle();
        #1;
        chk("t2_sum", res_sum, 64'd0);
        chk("t2_cout", res_cout, 1'b1);
        chk("t2_id", res_id, 2'd0);
        @(negedge clk);

        // All four requesters held valid.
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 64'(i * 16), 64'(i + 1), i[0]);
        res_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1 chk($sformatf("rr_id%0d", k), res_id, rr_ids[k]);
        end
        idle();
        @(negedge clk);

        // Backpressure on requester 1.
        do_reset();
        set_req(1, 64'd123, 64'd456, 1'b1);
        res_ready = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_ready", req_ready, 4'b0000);
            chk("bp_sum", res_sum, 64'd580);
            chk("bp_id", res_id, 2'd1);
            chk("bp_valid", res_valid, 1'b1);
            @(negedge clk);
        end
        res_ready = 1'b1;
        #1 chk("bp_release_ready", req_ready, 4'b0010);
        @(negedge clk);
        idle();
        #1;
        chk("bp_b2b_valid", res_valid, 1'b1);
        chk("bp_b2b_count", op_count, 32'd1);
        chk("bp_b2b_sum", res_sum, 64'd580);
        @(negedge clk);

        // Reset while FULL with op_count = 7.
        do_reset();
        set_req(0, 64'd5, 64'd6, 1'b0);
        res_ready = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        chk("mr_pre_count", op_count, 32'd7);
        chk("mr_pre_valid", res_valid, 1'b1);
        rst = 1'b1;
        #1;
        chk("mr_valid", res_valid, 1'b0);
        chk("mr_sum", res_sum, 64'd0);
        chk("mr_count", op_count, 32'd0);
        idle();
        @(negedge clk);
        rst = 1'b0;

        // op_count wrap.
        @(negedge clk);
        check_en = 1'b0;
        force dut.count_q = 32'hFFFF_FFFF;
        #1;
        release dut.count_q;
        m_count = 32'hFFFF_FFFF;
        check_en = 1'b1;
        @(negedge clk);
        set_req(3, 64'd10, 64'd20, 1'b0);
        res_ready = 1'b1;
        @(negedge clk);
        idle();
        #1 chk("wrap_pre", op_count, 32'hFFFF_FFFF);
        @(negedge clk);
        #1 chk("wrap_count", op_count, 32'd0);

        // Randomized traffic; a pending request holds its operands until accepted.
        pend = '0;
        repeat (600) begin
            @(negedge clk);
            pend = pend & ~m_acc;
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    set_req(i, rnd64(), rnd64(), 1'($urandom_range(0, 1)));
                    pend[i] = 1'b1;
                end
            end
            req_valid = pend;
            res_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        idle();
        res_ready = 1'b1;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/add_arbiter.md
# add_arbiter

Shares one 64-bit carry-select adder among `N_REQ` requesters. Each requester presents an operand pair and a carry-in under a valid/ready handshake. The block grants one requester per cycle, registers the adder result in a single-entry output buffer tagged with the requester index, and holds it until the consumer accepts it. It sits between the execution clients and the shared adder datapath, and is the only block that drives the adder inputs.

## Interface
Parameters:
- `N_REQ`, 4 — number of requesters; power of two, 2..8.
- `W`, 64 — operand width; fixed at 64 to match the shared adder.

Ports:
- `clk` in 1 — single clock, rising edge.
- `rst` in 1 — reset, asynchronous, active-high.
- `req_valid` in N_REQ — per-requester operand valid.
- `req_ready` out N_REQ — per-requester accept; at most one bit high per cycle.
- `req_a` in N_REQ*W — operand A, requester i at bits [i*W +: W].
- `req_b` in N_REQ*W — operand B, same packing as `req_a`.
- `req_cin` in N_REQ — per-requester carry-in.
- `res_valid` out 1 — output buffer holds a result.
- `res_ready` in 1 — consumer accepts the result.
- `res_sum` out W — registered sum.
- `res_cout` out 1 — registered carry-out.
- `res_id` out $clog2(N_REQ) — index of the requester that produced the result.
- `op_count` out 32 — number of completed output handshakes; wraps at 2^32.

## Operation
- FSM has two states:
  - EMPTY: `res_valid`=0.
  - FULL: `res_valid`=1.
- Definitions:
  - `can_accept` = EMPTY, or (FULL and `res_ready`).
  - `grant` = one-hot selection among the set `req_valid` bits.
- `req_ready[i]` = `grant[i]` & `can_accept`. This path is combinational from `req_valid` and `res_ready`. Requesters must not make `req_valid` depend on `req_ready`.
- Accepting a request (`req_valid[i]` & `req_ready[i]`):
  - loads `res_sum`/`res_cout` = {a_i + b_i + cin_i} (65-bit result, carry in bit 64);
  - loads `res_id` = i;
  - moves the FSM to FULL.
- Output handshake (FULL & `res_ready`) with no new accept: FSM goes to EMPTY.
- Simultaneous drain and accept: FSM stays FULL with the new data, giving back-to-back throughput of 1 per cycle.
- FULL & !`res_ready`: `res_sum`, `res_cout` and `res_id` hold stable. All `req_ready` bits are 0.
- `op_count` increments by 1 on every output handshake and wraps from 0xFFFF_FFFF to 0.
- Arbitration pointer `prio`, width $clog2(N_REQ):
  - The search starts at `prio` and rises modulo N_REQ.
  - After an accept from requester i, `prio` becomes (i+1) mod N_REQ.
  - `prio` is unchanged on cycles with no accept.
- Arithmetic is unsigned modulo 2^64. Carry-out reports bit 64.

## Timing
- Reset values: `res_valid`=0, `res_sum`=0, `res_cout`=0, `res_id`=0, `op_count`=0, `prio`=0, FSM=EMPTY, `req_ready`=0.
- Reset applies immediately on `rst` rise, including mid-operation. A buffered result is discarded without a handshake and `op_count` is not incremented.
- Latency: request accepted at edge k gives `res_valid`=1 with its data after edge k.
- Throughput: one result per cycle while `res_ready`=1 and any `req_valid` is set.
- A request whose `req_ready` is low must hold `req_a`, `req_b` and `req_cin` until it is accepted. The block samples them only on the accepting edge.

## Configuration
- `ADD_ARB_RR_EN` defined: round-robin arbitration with the rotating `prio`, as described above.
- `ADD_ARB_RR_EN` undefined: fixed priority, lowest index wins. `prio` is not implemented and is treated as constantly 0. Starvation of high indices is permitted.

## Structure
Shared package `add_arb_pkg` holds:
- `ADD_W` = 64;
- the `arb_state_t` enum {EMPTY, FULL};
- the `add_res_t` struct {sum[63:0], cout}.

One sub-module, `add64_cs`:
- combinational 64-bit carry-select adder;
- two 32-bit halves; upper half precomputed for carry 0 and carry 1 and muxed on the lower carry-out;
- instantiated once, with inputs driven by the granted requester's operands.

## Test plan
- Reset then single request: req 2 sends a=0xFFFF_FFFF, b=1, cin=0 with `res_ready`=1 → next cycle `res_sum`=0x1_0000_0000, `res_cout`=0, `res_id`=2, `op_count`=1.
- Carry-out: a=0xFFFF_FFFF_FFFF_FFFF, b=0, cin=1 → `res_sum`=0, `res_cout`=1.
- Round-robin (`ADD_ARB_RR_EN`): all four `req_valid` held high, `res_ready`=1 → `res_id` sequence 0,1,2,3,0. Fixed-priority build gives 0,0,0,0.
- Backpressure: hold `res_ready`=0 for 5 cycles with req 1 valid → output stable, `req_ready`=0. Raise `res_ready` → same-cycle accept of req 1, back-to-back result next cycle.
- Mid-operation reset: assert `rst` while FULL with `op_count`=7 → `res_valid`=0, `res_sum`=0, `op_count`=0 immediately, without waiting for a clock edge.
- Wrap: force `op_count` to 0xFFFF_FFFF, complete one handshake → `op_count`=0.
